// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : Multi-cycle execute unit. Single-cycle add/sub/compare/logic,
//             iterative one-bit-per-cycle shifts, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
  // Operand/result width; the 5-bit shift amount ties this to 32.
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_alu_op,
  input  logic                  in_regwrite,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [4:0]            in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_regwrite,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  // State and datapath registers. res_q doubles as the shift register so the
  // partial shift value and the final result share one set of flops.
  logic [1:0]            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  op_is_shift;
  logic                  op_is_valid;
  logic [4:0]            shamt;

  assign shamt       = in_rs2[4:0];
  assign op_is_shift = (in_alu_op == OP_SLL) || (in_alu_op == OP_SRL) ||
                       (in_alu_op == OP_SRA);
  assign op_is_valid = (in_alu_op <= OP_AND);

  // Single-cycle result; shifts only ever reach here with shamt 0, so they
  // pass operand A through unchanged and no barrel shifter is built.
  always_comb begin
    alu_res = '0;
    case (in_alu_op)
      OP_ADD:  alu_res = in_rs1 + in_rs2;
      OP_SUB:  alu_res = in_rs1 - in_rs2;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (in_rs1 < in_rs2)};
      OP_XOR:  alu_res = in_rs1 ^ in_rs2;
      OP_OR:   alu_res = in_rs1 | in_rs2;
      OP_AND:  alu_res = in_rs1 & in_rs2;
      OP_SLL, OP_SRL, OP_SRA: alu_res = in_rs1;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, step the shifter, hold DONE until taken.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = in_alu_op;
          rd_d = in_rd;
          rw_d = in_regwrite && op_is_valid;
          if (op_is_shift && (shamt != 5'd0)) begin
            res_d   = in_rs1;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            res_d   = alu_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SLL:  res_d = {res_q[DATA_WIDTH-2:0], 1'b0};
          OP_SRL:  res_d = {1'b0, res_q[DATA_WIDTH-1:1]};
          default: res_d = {res_q[DATA_WIDTH-1], res_q[DATA_WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - 5'd1;
        // A count of 1 means this cycle performs the final shift.
        if (cnt_q == 5'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      res_q   <= '0;
      cnt_q   <= 5'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  // Handshake flags are pure functions of state.
  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign out_result   = res_q;
  assign out_rd       = rd_q;
  assign out_regwrite = rw_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Self-checking bench for alu_exec: directed cases plus
//             randomized traffic against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_op = 4'd0;
  logic        in_regwrite = 1'b0;
  logic [31:0] in_rs1 = 32'd0;
  logic [31:0] in_rs2 = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_op    (in_alu_op),
    .in_regwrite  (in_regwrite),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles spent busy before the result appears (0 for single-cycle ops).
  function automatic int ref_wait(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]);
    return 0;
  endfunction

  // Transaction model: 0 idle, 1 working, 2 result presented.
  logic [1:0]  m_ph;
  int          m_wait;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 2'd0;
      m_wait <= 0;
      m_acc  <= 1'b0;
      m_res  <= 32'd0;
      m_rd   <= 5'd0;
      m_rw   <= 1'b0;
    end else begin
      m_acc <= 1'b0;
      case (m_ph)
        2'd0: if (in_valid) begin
          m_acc  <= 1'b1;
          m_res  <= ref_alu(in_alu_op, in_rs1, in_rs2);
          m_rd   <= in_rd;
          m_rw   <= in_regwrite && (in_alu_op <= 4'd9);
          m_wait <= ref_wait(in_alu_op, in_rs2);
          m_ph   <= (ref_wait(in_alu_op, in_rs2) == 0) ? 2'd2 : 2'd1;
        end
        2'd1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_ph <= 2'd2;
        end
        default: if (out_ready) m_ph <= 2'd0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ph == 2'd0});
      chk("busy", {31'd0, busy}, {31'd0, m_ph != 2'd0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ph == 2'd2});
      if (m_ph == 2'd2) begin
        chk("out_result", out_result, m_res);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, m_rw});
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic [31:0] e_res,
                       input logic e_rw, input int e_lat, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_alu_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    in_regwrite = rw; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk({nm, "_busy"}, {30'd0, in_ready, busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_result"}, out_result, e_res);
    chk({nm, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({nm, "_regwrite"}, {31'd0, out_regwrite}, {31'd0, e_rw});
  endtask

  initial begin
    int lat;
    // Reset values while reset is held.
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outs", {out_valid, busy, out_regwrite, out_rd, out_result[25:0]}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Directed cases with hand-computed expectations.
    do_op(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b1, 1, "add");
    do_op(4'b0001, 32'd3, 32'd5, 5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1, 1, "sub");
    do_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd1, 1'b1, 1, "slt");
    do_op(4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0, 1'b1, 1, "sltu");
    do_op(4'b0111, 32'h8000_0000, 32'h24, 5'd7, 1'b1, 32'hF800_0000, 1'b1, 5, "sra");
    do_op(4'b0110, 32'h8000_0000, 32'h24, 5'd8, 1'b1, 32'h0800_0000, 1'b1, 5, "srl");
    do_op(4'b0010, 32'd1, 32'd31, 5'd9, 1'b1, 32'h8000_0000, 1'b1, 32, "sll31");
    do_op(4'b0010, 32'hABCD, 32'h20, 5'd10, 1'b1, 32'hABCD, 1'b1, 1, "sll0");
    do_op(4'b1111, 32'h1234, 32'd0, 5'd11, 1'b1, 32'd0, 1'b0, 1, "invalid");

    // Backpressure: result held, pending request waits.
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = 4'd0; in_rs1 = 32'd10; in_rs2 = 32'd20; in_rd = 5'd7;
    in_regwrite = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_rs1 = 32'd100; in_rs2 = 32'd1; in_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {out_valid, in_ready, 25'd0, out_rd}, {1'b1, 1'b0, 25'd0, 5'd7});
      chk("bp_result", out_result, 32'd30);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pending_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second", {out_valid, 26'd0, out_rd}, {1'b1, 26'd0, 5'd12});
    chk("bp_second_result", out_result, 32'd101);

    // Reset in the middle of a shift.
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = 4'd2; in_rs1 = 32'd1; in_rs2 = 32'd10; in_rd = 5'd13;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_outs", {out_valid, busy, out_regwrite, 24'd0, out_rd}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    do_op(4'b0000, 32'd1, 32'd1, 5'd1, 1'b1, 32'd2, 1'b1, 1, "post_rst_add");

    // Randomized traffic; the source holds each request until taken.
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!in_valid || m_acc) begin
        in_valid = ($urandom % 4) != 0;
        lat = int'($urandom % 13);
        in_alu_op = (lat < 10) ? 4'(lat) : 4'($urandom_range(10, 15));
        in_rs1 = $urandom;
        in_rs2 = (($urandom % 2) != 0) ? $urandom : 32'($urandom % 40);
        in_rd = 5'($urandom);
        in_regwrite = 1'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    lat = 0;
    while (busy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("drain_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
